// File: rtl/dmi_jtag_host.sv
// dmi_jtag_host: JTAG initiator running IR/DR scans from a single clock; TCK = clk/(2*ClkDiv).
// Define DMI_JTAG_HOST_TAP_RESET_EN to make op=10 replay the TMS reset sequence.
module dmi_jtag_host #(
    parameter int ClkDiv = 4,
    parameter int MaxLen = 41,
    localparam int LW = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              trst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [LW-1:0]     req_len_i,
    input  logic [MaxLen-1:0] req_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [MaxLen-1:0] resp_data_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i,
    output logic              trst_no
);
    localparam int DW = $clog2(2 * ClkDiv);

    typedef enum logic [2:0] {INIT, IDLE, HDR, SHIFT, TAIL, RESP} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [LW-1:0]     cnt_q, cnt_d, len_q, len_d, len_c;
    logic [1:0]        op_q, op_d;
    logic [MaxLen-1:0] data_q, data_d, rdata_q, rdata_d;
    logic              tck_d, tms_d, tdi_d;
    logic              active, rise, pe, last, ir, tap_rst;

`ifdef DMI_JTAG_HOST_TAP_RESET_EN
    assign tap_rst = 1'b1;
`else
    assign tap_rst = 1'b0;
`endif

    // TMS value for period c of a given phase
    function automatic logic tms_at(state_t s, logic [LW-1:0] c, logic is_ir, logic [LW-1:0] n);
        return s == INIT  ? c < LW'(5) :
               s == HDR   ? (is_ir ? c < LW'(2) : c == '0) :
               s == SHIFT ? c == n - LW'(1) : c == '0;
    endfunction

    assign ir     = op_q == 2'b01;
    assign active = state_q inside {INIT, HDR, SHIFT, TAIL};
    assign rise   = active && div_q == DW'(ClkDiv - 1);
    assign pe     = active && div_q == DW'(2 * ClkDiv - 1);
    assign last   = state_q == INIT  ? cnt_q == LW'(5) :
                    state_q == HDR   ? cnt_q == (ir ? LW'(3) : LW'(2)) :
                    state_q == SHIFT ? cnt_q == len_q - LW'(1) : cnt_q == LW'(1);
    assign len_c  = req_len_i > LW'(MaxLen) ? LW'(MaxLen) : req_len_i;
    assign tck_d  = active && div_d >= DW'(ClkDiv);

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign resp_data_o  = rdata_q;
    assign trst_no      = trst_ni;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        tms_d   = tms_o;
        tdi_d   = tdi_o;
        if (active) div_d = pe ? '0 : div_q + DW'(1);
        if (rise && state_q == SHIFT) rdata_d[cnt_q] = tdo_i;
        if (pe && !last) begin
            cnt_d = cnt_q + LW'(1);
            tms_d = tms_at(state_q, cnt_d, ir, len_q);
            tdi_d = state_q == SHIFT && data_q[cnt_d];
        end else if (pe) begin
            cnt_d   = '0;
            state_d = state_q == INIT  ? (op_q == 2'b10 ? RESP : IDLE) :
                      state_q == HDR   ? SHIFT :
                      state_q == SHIFT ? TAIL : RESP;
            tms_d   = state_q == HDR ? len_q == LW'(1) : state_q == SHIFT;
            tdi_d   = state_q == HDR && data_q[0];
        end
        if (state_q == IDLE && req_valid_i) begin
            op_d    = req_op_i;
            len_d   = len_c;
            data_d  = req_data_i;
            rdata_d = '0;
            cnt_d   = '0;
            div_d   = '0;
            state_d = req_op_i == 2'b10 ? (tap_rst ? INIT : RESP) :
                      (req_op_i == 2'b11 || len_c == '0) ? RESP : HDR;
            tms_d   = state_d inside {INIT, HDR};
        end
        if (state_q == RESP && resp_ready_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= INIT;
            div_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            tck_o   <= 1'b0;
            tms_o   <= 1'b1;
            tdi_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            tck_o   <= tck_d;
            tms_o   <= tms_d;
            tdi_o   <= tdi_d;
        end
    end
endmodule

// File: tb/tb_dmi_jtag_host.sv
// tb_dmi_jtag_host: drives dmi_jtag_host against a behavioural TAP (IDCODE=1, IR capture 00101, bypass).
module tb_dmi_jtag_host;
    localparam int MaxLen = 41;
    localparam int LW = 6;
`ifdef DMI_JTAG_HOST_TAP_RESET_EN
    localparam int TrPer = 6;
`else
    localparam int TrPer = 0;
`endif

    logic              clk = 0, trst_ni = 0, req_valid = 0, resp_ready = 0, tdo = 0;
    logic              req_ready, resp_valid, tck, tms, tdi, trst_n;
    logic [1:0]        req_op = 0;
    logic [LW-1:0]     req_len = 0;
    logic [MaxLen-1:0] req_data = 0, resp_data;

    always #5 clk = ~clk;

    dmi_jtag_host #(.ClkDiv(4), .MaxLen(MaxLen)) dut (
        .clk_i(clk), .trst_ni(trst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_len_i(req_len), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_n)
    );

    typedef enum logic [3:0] {TLR, RTI, SDS, CD, SD, E1D, PD, E2D, UD, SIS, CI, SI, E1I, PI, E2I, UI} tap_t;
    tap_t        ts;
    logic [4:0]  ir, ir_sh;
    logic [31:0] idr;
    logic        byp;

    function automatic tap_t next_ts(tap_t s, logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CD;
            CD, SD: return m ? E1D : SD;
            E1D: return m ? UD : PD;
            PD: return m ? E2D : PD;
            E2D: return m ? UD : SD;
            SIS: return m ? TLR : CI;
            CI, SI: return m ? E1I : SI;
            E1I: return m ? UI : PI;
            PI: return m ? E2I : PI;
            E2I: return m ? UI : SI;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ts <= TLR;
            ir <= 5'h01;
        end else begin
            case (ts)
                TLR: ir <= 5'h01;
                CD: if (ir == 5'h01) idr <= 32'h1; else byp <= 1'b0;
                SD: if (ir == 5'h01) idr <= {tdi, idr[31:1]}; else byp <= tdi;
                CI: ir_sh <= 5'b00101;
                SI: ir_sh <= {tdi, ir_sh[4:1]};
                UI: ir <= ir_sh;
                default: ;
            endcase
            ts <= next_ts(ts, tms);
        end
    end

    always @(negedge tck or negedge trst_n)
        if (!trst_n) tdo <= 1'b0;
        else tdo <= ts == SD ? (ir == 5'h01 ? idr[0] : byp) : ts == SI ? ir_sh[0] : 1'b0;

    int rises = 0, cyc = 0, last_rise = 0, per_clks = 0;
    logic [7:0] tms_log = 0;
    always @(posedge clk) cyc++;
    always @(posedge tck) begin
        rises++;
        tms_log = {tms_log[6:0], tms};
        per_clks = cyc - last_rise;
        last_rise = cyc;
    end

    int tests = 0, fails = 0;
    logic [MaxLen-1:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [MaxLen-1:0] d,
                         input logic [MaxLen-1:0] exp);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) expired("req_ready");
        req_op = op;
        req_len = len;
        req_data = d;
        req_valid = 1;
        sb.push_back(exp);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic get_resp(input string name);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000 || sb.size() == 0) begin
            expired(name);
            return;
        end
        chk(name, resp_data, sb.pop_front());
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [LW-1:0]     len;
        logic [MaxLen-1:0] data;
        logic [MaxLen-1:0] exp;
        int                per;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int n, r0, ok;
        logic seen;
        tbl[0]  = '{2'b01, 6'd5,  41'h1,        41'h5,            11};
        tbl[1]  = '{2'b00, 6'd32, 41'h0,        41'h1,            37};
        tbl[2]  = '{2'b00, 6'd1,  41'h0,        41'h1,            6};
        tbl[3]  = '{2'b00, 6'd41, 41'h0FF,      41'h0FF_0000_0001, 46};
        tbl[4]  = '{2'b00, 6'd50, 41'h0FF,      41'h0FF_0000_0001, 46};
        tbl[5]  = '{2'b01, 6'd5,  41'h1F,       41'h5,            11};
        tbl[6]  = '{2'b00, 6'd8,  41'hA5,       41'h4A,           13};
        tbl[7]  = '{2'b00, 6'd0,  41'h3,        41'h0,            0};
        tbl[8]  = '{2'b11, 6'd5,  41'h3,        41'h0,            0};
        tbl[9]  = '{2'b10, 6'd5,  41'h3,        41'h0,            TrPer};
        tbl[10] = '{2'b01, 6'd5,  41'h1,        41'h5,            11};
        tbl[11] = '{2'b00, 6'd32, 41'hDEADBEEF, 41'h1,            37};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {tck, tms, tdi, req_ready, resp_valid, trst_n, resp_data}, {6'b010000, 41'h0});
        rises = 0;
        trst_ni = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        chk("init_ready_clks", n, 48);
        chk("init_periods", rises, 6);
        chk("init_tms_seq", tms_log[5:0], 6'b111110);
        chk("init_period_clks", per_clks, 8);
        chk("init_tap_rti", ts, RTI);

        for (int i = 0; i < 12; i++) begin
            r0 = rises;
            issue(tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].exp);
            get_resp($sformatf("vec%0d_data", i));
            chk($sformatf("vec%0d_periods", i), rises - r0, tbl[i].per);
            chk($sformatf("vec%0d_tap_rti", i), ts, RTI);
        end

        r0 = rises;
        issue(2'b00, 6'd0, 41'h1, 41'h0);
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid && !req_ready) ok++;
        end
        chk("len0_hold", ok, 10);
        chk("len0_no_tck", rises - r0, 0);
        get_resp("len0_data");
        @(negedge clk);
        chk("ready_after_take", req_ready, 1);

        r0 = rises;
        issue(2'b00, 6'd41, 41'h1FF_FFFF_FFFF, 41'h0);
        n = 0;
        while (rises < r0 + 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) expired("abort_wait");
        #2 trst_ni = 0;
        #1 chk("abort_outputs", {tck, tms, tdi, req_ready, resp_valid, trst_n, resp_data}, {6'b010000, 41'h0});
        sb.delete();
        repeat (2) @(negedge clk);
        r0 = rises;
        seen = 0;
        trst_ni = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (resp_valid) seen = 1;
        end while (!req_ready && n < 200);
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("abort_ready_clks", n, 48);
        chk("abort_reinit_periods", rises - r0, 6);
        chk("abort_no_resp", seen, 0);
        chk("abort_tap_rti", ts, RTI);

        issue(2'b00, 6'd32, 41'h0, 41'h1);
        get_resp("post_abort_idcode");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmi_jtag_host.md
# dmi_jtag_host

JTAG initiator that drives a TAP's pins from a single system clock. It generates TCK, TMS, TDI and TRST, and samples TDO. It executes IR scans and DR scans requested over a valid/ready command port and returns the shifted-out bits on a response port. It is used as an on-chip JTAG master and as the bench driver for `dmi_jtag_tap` (DTMCS/DMI access without an external probe).

## Interface
Parameters:
- ClkDiv, 4: system clocks per TCK half-period. Must be ≥1.
- MaxLen, 41: maximum scan length in bits (DMI width 7+32+2).

Ports:
- clk_i  in  1  system clock
- trst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid & ready
- req_op_i  in  2  00 DR scan, 01 IR scan, 10 TAP reset (see Configuration), 11 reserved (no-op)
- req_len_i  in  $clog2(MaxLen+1)  scan length in bits
- req_data_i  in  MaxLen  TDI bits, LSB shifted first
- resp_valid_o  out  1  response valid, held until taken
- resp_ready_i  in  1  response consumer ready
- resp_data_o  out  MaxLen  sampled TDO bits, bit i = i-th shifted bit, upper bits zero
- tck_o  out  1  JTAG clock
- tms_o  out  1  test mode select
- tdi_o  out  1  test data to TAP
- tdo_i  in  1  test data from TAP
- trst_no  out  1  TAP reset, follows trst_ni

## Operation
- FSM states: INIT, IDLE, HDR, SHIFT, TAIL, RESP.
- INIT: entered on reset release. Runs 5 TCK periods with TMS=1, then 1 with TMS=0, leaving the TAP in RunTestIdle. req_ready_o=0 during INIT. Then goes to IDLE.
- IDLE: req_ready_o=1 only here. On accept, the block latches op, len and data. Len is clamped to MaxLen.
- len=0 or op=11: no TCK activity. Go to RESP with resp_data_o=0.
- HDR TMS sequence: DR = 1,0,0 (SelectDr, CaptureDr, ShiftDr). IR = 1,1,0,0.
- SHIFT: len TCK periods. TDI = data[i]. TMS=0 except the last bit, which has TMS=1 (exit to Exit1). tdo_i is sampled into bit i on the rising TCK edge of period i.
- TAIL: TMS = 1,0 (Update, RunTestIdle).
- RESP: resp_valid_o=1 until resp_ready_i. Then go to IDLE. The next command cannot be accepted in the same cycle the response is taken.
- The TAP is always left in RunTestIdle between commands. tck_o idles low.

## Timing
- One TCK period = 2·ClkDiv clk cycles: low half, then high half.
- tms_o and tdi_o change only on the clk edge that starts a low half (TCK falling). They are stable across the rising edge.
- tdo_i is sampled on the clk edge that raises tck_o. The TAP updates TDO on the falling edge, so there is a half-period of setup.
- Scan duration: DR = len+5 TCK periods; IR = len+6. INIT = 6.
- resp_valid_o rises 1 clk after the final TCK period ends.
- Reset values: tck_o=0, tms_o=1, tdi_o=0, req_ready_o=0, resp_valid_o=0, resp_data_o=0, state INIT.
- Reset mid-scan aborts immediately. It discards any pending response and re-runs INIT.
- req_valid_i while busy is ignored and not lost; it stays pending at the requester.

## Configuration
- Macro DMI_JTAG_HOST_TAP_RESET_EN.
- Defined: op=10 runs the INIT sequence (5×TMS=1, 1×TMS=0), then responds with resp_data_o=0.
- Undefined: op=10 is treated as a no-op, with an immediate response of 0 and no TCK activity.
- Power-on INIT always runs, whether or not the macro is defined.

## Test plan
- Reset release with ClkDiv=4 -> exactly 6 TCK periods (TMS 1,1,1,1,1,0), each 8 clks. req_ready_o rises only afterwards.
- IR scan len=5, data=0x01, against `dmi_jtag_tap` -> resp_data_o=0x05 (capture pattern). The TAP IR then holds IDCODE.
- Following DR scan len=32, data=0, against a TAP with IdcodeValue 0x00000001 -> resp_data_o=0x00000001. The scan spans 37 TCK periods.
- IR scan 0x1F, then DR scan len=8, data=0xA5 -> resp_data_o=0x4A (bypass one-bit delay).
- len=0 request, and resp_ready_i held low for 10 clks -> no TCK toggles. resp_valid_o stays high 10 clks and req_ready_o stays 0 until the response is taken.
- trst_ni asserted in the middle of the SHIFT of a 41-bit DR scan -> outputs return to reset values in the same cycle. After release, INIT is re-run and no response is issued. With DMI_JTAG_HOST_TAP_RESET_EN defined, op=10 produces the 6-period TMS sequence.
